cc_wrap_serializer: RTL and testbench
=====================================

Name: cc_wrap_serializer

Overview:
Parametrised cache-line-to-beat serializer for the cache controller read-data path. It pops one {mode, byte offset, line} word from a first-word-fall-through (FWFT) FIFO and emits the line as LINE_W/BEAT_W beats on a valid/ready channel with rlast. In WRAP mode the critical beat goes first and the burst wraps; in INCR mode beats go out in order from beat 0. It supports zero-bubble back-to-back lines and holds data stable under backpressure.

Parameters:
LINE_W, 512, cache line width in bits; LINE_W/BEAT_W must be a power of 2 and at least 2
BEAT_W, 64, output beat width in bits; must be a multiple of 8
NBEATS, LINE_W/BEAT_W, beats per line (derived, localparam)
OFS_W, $clog2(LINE_W/8), byte-offset field width (derived)
IDX_W, $clog2(NBEATS), beat-index width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
fifo_empty_i  in  1  FIFO empty; fifo_rdata_i is valid whenever this is 0 (FWFT)
fifo_rdata_i  in  LINE_W+OFS_W+1  {mode[1], byte_ofs[OFS_W], line[LINE_W]}; mode 1=WRAP, 0=INCR
fifo_rden_o  out  1  pop strobe, combinational, at most 1 cycle per line
rdata_o  out  BEAT_W  beat data
rlast_o  out  1  final beat of the line
rvalid_o  out  1  beat valid
rready_i  in  1  downstream accept
busy_o  out  1  line held, i.e. FSM state SEND

Behaviour:
- Reset: rst_n=0 at posedge clears FSM to IDLE, beat counter, line register, start index and mode. Values after reset: rvalid_o=0, rlast_o=0, rdata_o=0, fifo_rden_o=0, busy_o=0. A reset mid-burst discards the partial line; no further beats of that line are emitted.
- States: IDLE, SEND.
- IDLE:
  - fifo_rden_o = !fifo_empty_i.
  - On a pop, capture in the same cycle: line, start_idx = byte_ofs[OFS_W-1 -: IDX_W] (the low byte-within-beat bits are ignored), mode. Clear cnt.
  - Go to SEND. First beat appears with rvalid_o=1 on the next cycle, so pop-to-first-beat latency is 1 cycle.
- SEND:
  - rvalid_o=1.
  - ptr = WRAP ? (start_idx+cnt) mod NBEATS : cnt, computed in IDX_W-bit arithmetic with natural wrap.
  - rdata_o = line[ptr*BEAT_W +: BEAT_W].
  - rlast_o = (cnt==NBEATS-1).
- Handshake:
  - A beat transfers only on rvalid_o && rready_i; cnt increments by 1 on each transfer.
  - While rready_i=0, rdata_o, rlast_o and ptr are held unchanged.
  - rvalid_o never drops before its beat is accepted.
- Last-beat transfer:
  - If !fifo_empty_i in that same cycle: fifo_rden_o=1, the next line is captured, state stays SEND, cnt resets to 0. The next line's first beat is valid the following cycle with no bubble.
  - Otherwise: go to IDLE, rvalid_o=0 the next cycle.
- fifo_rden_o is 0 in SEND except on a last-beat transfer. It is never asserted when fifo_empty_i=1.
- rdata_o is forced to 0 whenever rvalid_o=0.
- INCR mode ignores byte_ofs.
- An offset pointing at beat 0 makes WRAP order identical to INCR order.
- rready_i asserted in IDLE has no effect.

Optional Feature:
Macro CC_SER_PERF_EN.
- Defined: adds output stall_cnt_o [31:0]. It increments on every cycle with rvalid_o && !rready_i, saturates at 32'hFFFF_FFFF, and is cleared by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, WRAP, byte_ofs=16, line beats k = 64'hk (k=0..7), rready_i=1 -> beats 2,3,4,5,6,7,0,1 on consecutive cycles; rlast_o only with beat 1; exactly one fifo_rden_o pulse.
- INCR, byte_ofs=40 -> beats 0..7 in order; rlast_o on beat 7.
- Two lines queued, rready_i=1 -> 16 consecutive valid beats, no bubble; second fifo_rden_o coincides with the first line's rlast_o transfer.
- WRAP, ofs=56, rready_i low for 3 cycles at the 2nd beat -> rdata_o=64'h0 held stable 4 cycles, no beat lost or duplicated; with CC_SER_PERF_EN, stall_cnt_o=3.
- Reset asserted after 3 beats -> next cycle rvalid_o=0, rlast_o=0, busy_o=0; a new line restarts at its critical beat.
- BEAT_W=128, LINE_W=512, WRAP, byte_ofs=48 -> beats 3,0,1,2; rlast_o on beat 2.

Source files
------------

// File: rtl/cc_wrap_serializer.sv
// Cache-line to beat serializer: pops {mode, byte_ofs, line} from an FWFT FIFO and streams
// critical-beat-first WRAP or in-order INCR beats. Optional stall counter under CC_SER_PERF_EN.
module cc_wrap_serializer #(
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64,
    localparam int NBEATS = LINE_W / BEAT_W,
    localparam int OFS_W  = $clog2(LINE_W / 8),
    localparam int IDX_W  = $clog2(NBEATS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_empty_i,
    input  logic [LINE_W+OFS_W:0]     fifo_rdata_i,
    output logic                      fifo_rden_o,
    output logic [BEAT_W-1:0]         rdata_o,
    output logic                      rlast_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic                      busy_o
`ifdef CC_SER_PERF_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    state_t             state_q, state_d;
    logic [LINE_W-1:0]  line_q;
    logic [IDX_W-1:0]   start_q;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               mode_q;

    logic [IDX_W-1:0]   ptr;
    logic               pop;
    logic               last_beat;

    // FIFO word fields; only the beat-select bits of the byte offset matter.
    logic               in_mode;
    logic [IDX_W-1:0]   in_start;
    logic [LINE_W-1:0]  in_line;

    assign in_mode  = fifo_rdata_i[LINE_W+OFS_W];
    assign in_start = fifo_rdata_i[LINE_W+OFS_W-1 -: IDX_W];
    assign in_line  = fifo_rdata_i[LINE_W-1:0];

    generate
        if (OFS_W > IDX_W) begin : g_ofs_lsb
            logic ofs_lsb_unused;
            assign ofs_lsb_unused = ^fifo_rdata_i[LINE_W +: (OFS_W - IDX_W)];
        end
    endgenerate

    // Handshake: a beat transfers on rvalid_o && rready_i. While rvalid_o is high and
    // rready_i is low, rdata_o/rlast_o stay frozen and rvalid_o stays high. A pop happens
    // in IDLE whenever the FIFO is non-empty, or in SEND only on the last-beat transfer,
    // which reloads the line register so the next burst follows without a bubble.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        last_beat   = 1'b0;
        rvalid_o    = 1'b0;
        rlast_o     = 1'b0;
        busy_o      = 1'b0;
        rdata_o     = '0;
        ptr         = mode_q ? (start_q + cnt_q) : cnt_q;

        case (state_q)
            IDLE: begin
                if (rst_n && !fifo_empty_i) begin
                    pop     = 1'b1;
                    state_d = SEND;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                rvalid_o  = 1'b1;
                busy_o    = 1'b1;
                last_beat = (cnt_q == LAST_IDX);
                rlast_o   = last_beat;
                rdata_o   = line_q[ptr*BEAT_W +: BEAT_W];
                if (rready_i) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        if (rst_n && !fifo_empty_i) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_rden_o = pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            line_q  <= '0;
            start_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                line_q  <= in_line;
                start_q <= in_start;
                mode_q  <= in_mode;
            end
        end
    end

`ifdef CC_SER_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a beat is offered but not taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (rvalid_o && !rready_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_cc_wrap_serializer.sv
// Directed bench for cc_wrap_serializer: a FIFO model feeds the 64-bit-beat instance and a
// scoreboard of hand-ordered beats checks it; a second 128-bit-beat instance is checked inline.
module tb_cc_wrap_serializer;

    localparam int LW  = 512;
    localparam int BW  = 64;
    localparam int OW  = 6;
    localparam int FW  = LW + OW + 1;
    localparam int BW2 = 128;

    logic           clk;
    logic           rst_n;

    logic           fifo_empty_i;
    logic [FW-1:0]  fifo_rdata_i;
    logic           fifo_rden_o;
    logic [BW-1:0]  rdata_o;
    logic           rlast_o;
    logic           rvalid_o;
    logic           rready_i;
    logic           busy_o;

    logic           f2_empty;
    logic [FW-1:0]  f2_rdata;
    logic           rden2;
    logic [BW2-1:0] rdata2;
    logic           rlast2;
    logic           rvalid2;
    logic           rready2;
    logic           busy2;

`ifdef CC_SER_PERF_EN
    logic [31:0]    stall_cnt_o;
    logic [31:0]    stall2;
`endif

    cc_wrap_serializer #(.LINE_W(LW), .BEAT_W(BW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rden_o  (fifo_rden_o),
        .rdata_o      (rdata_o),
        .rlast_o      (rlast_o),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .busy_o       (busy_o)
`ifdef CC_SER_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    cc_wrap_serializer #(.LINE_W(LW), .BEAT_W(BW2)) dut128 (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (f2_empty),
        .fifo_rdata_i (f2_rdata),
        .fifo_rden_o  (rden2),
        .rdata_o      (rdata2),
        .rlast_o      (rlast2),
        .rvalid_o     (rvalid2),
        .rready_i     (rready2),
        .busy_o       (busy2)
`ifdef CC_SER_PERF_EN
        ,
        .stall_cnt_o  (stall2)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errs;

    logic [BW:0]   exp_q[$];
    logic [FW-1:0] fifo_q[$];

    int cyc;
    int beats;
    int first_cyc;
    int last_cyc;
    int rden_cnt;
    int rden_cyc;
    int rden_on_last;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] make_line(input logic [BW-1:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / BW; k++) l[k*BW +: BW] = base + BW'(k);
        return l;
    endfunction

    function automatic logic [BW2-1:0] beat128(input int k);
        return {32'hC0DE_0000 + 32'(k), 64'h0123_4567_89AB_CDEF, 32'h0000_0100 + 32'(k)};
    endfunction

    function automatic logic [LW-1:0] make_line128();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / BW2; k++) l[k*BW2 +: BW2] = beat128(k);
        return l;
    endfunction

    task automatic refresh_fifo();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_rdata_i = fifo_empty_i ? '0 : fifo_q[0];
    endtask

    // Driver tasks
    task automatic push_line(input logic mode, input logic [OW-1:0] ofs, input logic [BW-1:0] base);
        fifo_q.push_back({mode, ofs, make_line(base)});
        refresh_fifo();
    endtask

    task automatic expect_seq(input logic [BW-1:0] base, input int ord[8]);
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), base + BW'(ord[i])});
    endtask

    task automatic clear_stats();
        beats = 0; first_cyc = 0; last_cyc = 0;
        rden_cnt = 0; rden_cyc = 0; rden_on_last = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        rready_i = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        refresh_fifo();
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One cycle: scoreboard the beat at negedge, then pop the FIFO model after the edge.
    task automatic tick();
        logic [BW:0] e;
        logic        pop;
        @(negedge clk);
        cyc++;
        if (rvalid_o && rready_i) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {rlast_o, rdata_o}, '1);
            end else begin
                e = exp_q.pop_front();
                check("beat", {rlast_o, rdata_o}, e);
            end
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
        end
        if (!rvalid_o) check("idle_zero", {rlast_o, rdata_o}, '0);
        pop = fifo_rden_o;
        if (pop) begin
            rden_cnt++;
            if (rden_cnt == 1) rden_cyc = cyc;
            if (rvalid_o && rready_i && rlast_o) rden_on_last++;
            if (fifo_empty_i) check("rden_when_empty", fifo_rden_o, 1'b0);
        end
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic run_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
            tick();
        end
        check("drain", exp_q.size(), 0);
        check("back_idle", rvalid_o, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rvalid"}, rvalid_o, 1'b0);
        check({tag, "_rlast"}, rlast_o, 1'b0);
        check({tag, "_rdata"}, rdata_o, '0);
        check({tag, "_rden"}, fifo_rden_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        int ord[8];
        int ord4[4];
        checks = 0; errs = 0; cyc = 0;
        fifo_empty_i = 1'b1; fifo_rdata_i = '0; rready_i = 1'b0;
        f2_empty = 1'b1; f2_rdata = '0; rready2 = 1'b0;
        clear_stats();

        do_reset(2);
        check_idle("reset");
        check("reset_w128_valid", rvalid2, 1'b0);

        // WRAP, byte_ofs=16: critical beat 2 first
        clear_stats();
        rready_i = 1'b1;
        tick();
        check("idle_rready_noeffect", rvalid_o, 1'b0);
        push_line(1'b1, 6'd16, 64'h0);
        ord = '{2, 3, 4, 5, 6, 7, 0, 1};
        expect_seq(64'h0, ord);
        run_drain(30);
        check("wrap_beats", beats, 8);
        check("wrap_rden_pulses", rden_cnt, 1);
        check("wrap_latency", first_cyc - rden_cyc, 1);
        check("wrap_no_bubble", last_cyc - first_cyc + 1, 8);

        // INCR ignores byte_ofs=40
        clear_stats();
        push_line(1'b0, 6'd40, 64'hA5A5_0000_0000_0100);
        ord = '{0, 1, 2, 3, 4, 5, 6, 7};
        expect_seq(64'hA5A5_0000_0000_0100, ord);
        run_drain(30);
        check("incr_beats", beats, 8);
        check("incr_rden_pulses", rden_cnt, 1);

        // Two queued lines back to back
        clear_stats();
        push_line(1'b1, 6'd8, 64'h1111_0000_0000_0000);
        push_line(1'b0, 6'd9, 64'h2222_0000_0000_0000);
        ord = '{1, 2, 3, 4, 5, 6, 7, 0};
        expect_seq(64'h1111_0000_0000_0000, ord);
        ord = '{0, 1, 2, 3, 4, 5, 6, 7};
        expect_seq(64'h2222_0000_0000_0000, ord);
        run_drain(40);
        check("b2b_beats", beats, 16);
        check("b2b_no_bubble", last_cyc - first_cyc + 1, 16);
        check("b2b_rden_pulses", rden_cnt, 2);
        check("b2b_rden_on_rlast", rden_on_last, 1);

        // WRAP ofs=56 with a 3-cycle stall on the second beat
        do_reset(2);
        clear_stats();
        rready_i = 1'b1;
        push_line(1'b1, 6'd56, 64'h0);
        ord = '{7, 0, 1, 2, 3, 4, 5, 6};
        expect_seq(64'h0, ord);
        for (int i = 0; i < 10 && beats < 1; i++) tick();
        rready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rready_i = 1'b1;
            check("stall_valid", rvalid_o, 1'b1);
            check("stall_data", rdata_o, 64'h0);
            check("stall_last", rlast_o, 1'b0);
            check("stall_busy", busy_o, 1'b1);
            if (i < 3) tick();
        end
        run_drain(30);
        check("stall_beats", beats, 8);
`ifdef CC_SER_PERF_EN
        check("stall_cnt", stall_cnt_o, 32'd3);
`endif

        // Reset after 3 beats discards the line; new line restarts at its critical beat
        clear_stats();
        rready_i = 1'b1;
        push_line(1'b1, 6'd16, 64'h5000);
        ord = '{2, 3, 4, 5, 6, 7, 0, 1};
        expect_seq(64'h5000, ord);
        for (int i = 0; i < 10 && beats < 3; i++) tick();
        check("pre_reset_beats", beats, 3);
        do_reset(1);
        check_idle("mid_reset");
        clear_stats();
        rready_i = 1'b1;
        push_line(1'b1, 6'd24, 64'h6000);
        ord = '{3, 4, 5, 6, 7, 0, 1, 2};
        expect_seq(64'h6000, ord);
        run_drain(30);
        check("restart_beats", beats, 8);
        check("restart_latency", first_cyc - rden_cyc, 1);

        // 128-bit beats, WRAP byte_ofs=48 -> beats 3,0,1,2
        rready2 = 1'b1;
        f2_rdata = {1'b1, 6'd48, make_line128()};
        f2_empty = 1'b0;
        @(negedge clk);
        check("w128_rden", rden2, 1'b1);
        @(posedge clk);
        #1 f2_empty = 1'b1;
        ord4 = '{3, 0, 1, 2};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w128_valid", rvalid2, 1'b1);
            check("w128_beat", {rlast2, rdata2}, {(i == 3), beat128(ord4[i])});
        end
        @(negedge clk);
        check("w128_idle", rvalid2, 1'b0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        errs++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
